// File: rtl/div_sequential_pkg.sv
// Shared constants and state encodings for the multicycle divider.
package div_sequential_pkg;

    // Processor word width, shared with the multiplier
    localparam int WORD_WIDTH = 32;

    // Iteration counter width; 2**DIV_CNT_W must exceed WORD_WIDTH
    localparam int DIV_CNT_W = 6;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sequential_twos_negate.sv
// Two's-complement negation: bitwise invert followed by an increment,
// the same invert-plus-one scheme the ALU uses.
module twos_negate
    import div_sequential_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] inverted;

    // Bitwise inverter stage
    assign inverted = ~a;

    // Add one to complete the negation
    assign y = inverted + WIDTH'(1);

endmodule

// File: rtl/div_sequential.sv
// Multicycle signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per cycle, sign applied afterwards. Quotient truncates
// toward zero; the remainder is discarded.
module div_sequential
    import div_sequential_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] divisor_abs;
    logic             sign_q;
    logic             div0;

    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] neg_q;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (.a(data_operandA), .y(neg_a));
    twos_negate #(.WIDTH(WIDTH)) u_neg_b (.a(data_operandB), .y(neg_b));
    twos_negate #(.WIDTH(WIDTH)) u_neg_q (.a(dividend),      .y(neg_q));

    // Operand magnitudes; the most-negative value maps to itself and is
    // then treated as an unsigned magnitude, which divides correctly
    assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

    // Trial subtract: partial remainder plus inverted divisor with carry-in 1;
    // the carry out means the partial remainder is at least the divisor
    assign rem_shift = {remainder[WIDTH-2:0], dividend[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} + {1'b0, ~divisor_abs} + (WIDTH+1)'(1);
    assign q_bit     = trial[WIDTH];

    // Control FSM, iteration counter, shift registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= DIV_IDLE;
            count          <= '0;
            dividend       <= '0;
            remainder      <= '0;
            divisor_abs    <= '0;
            sign_q         <= 1'b0;
            div0           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_DIV) begin
            dividend       <= abs_a;
            divisor_abs    <= abs_b;
            sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0           <= (data_operandB == '0);
            remainder      <= '0;
            count          <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            state          <= DIV_RUN;
        end else begin
            case (state)
                DIV_IDLE: begin
                    data_resultRDY <= 1'b0;
                end
                DIV_RUN: begin
                    remainder <= q_bit ? trial[WIDTH-1:0] : rem_shift;
                    dividend  <= {dividend[WIDTH-2:0], q_bit};
                    count     <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH-1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    data_result    <= div0 ? '0 : (sign_q ? neg_q : dividend);
                    data_exception <= div0;
                    data_resultRDY <= 1'b1;
                    state          <= DIV_DONE;
                end
                DIV_DONE: begin
                    data_resultRDY <= 1'b0;
                    state          <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
